// File: rtl/eth_tx_frame_source.sv
// rtl/eth_tx_frame_source.sv - software-loaded frame buffer streamed to the MAC TX AXI-Stream input
// A frame is written byte-wise, then tx_start sends tx_len bytes with full backpressure and abort support.
module eth_tx_frame_source #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [ADDR_WIDTH:0]   tx_len,
  input  logic                  tx_start,
  input  logic                  tx_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  done_bad,
  output logic                  len_err,
  output logic [15:0]           frame_count,
  output logic [7:0]            tx_axis_tdata,
  output logic                  tx_axis_tvalid,
  input  logic                  tx_axis_tready,
  output logic                  tx_axis_tlast,
  output logic                  tx_axis_tuser
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  abort_act_q, abort_act_d;
  logic                  bad_q, bad_d;
  logic                  len_err_q, len_err_d;
  logic [15:0]           count_q, count_d;

  logic [7:0]            mem [DEPTH];
  logic [7:0]            rdata_q;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  in_send;
  logic                  is_last;
  logic                  beat_last;
  logic                  accept;

  assign in_send   = (state_q == S_SEND);
  assign is_last   = (idx_q == len_q - 1'b1);
  // abort_act applies to the beat on the bus; abort_pend only arms the beat after acceptance
  assign beat_last = is_last | abort_act_q;
  assign accept    = in_send & tx_axis_tready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    abort_pend_d = abort_pend_q;
    abort_act_d  = abort_act_q;
    bad_d        = bad_q;
    len_err_d    = 1'b0;
    count_d      = count_q;
    rd_addr      = idx_q[ADDR_WIDTH-1:0];
    case (state_q)
      S_IDLE: begin
        rd_addr = '0;
        if (tx_start) begin
          if ((tx_len != '0) && (tx_len <= DEPTH_LEN)) begin
            len_d        = tx_len;
            idx_d        = '0;
            abort_pend_d = 1'b0;
            abort_act_d  = 1'b0;
            bad_d        = 1'b0;
            state_d      = S_PRIME;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_PRIME: begin
        rd_addr = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_abort && !beat_last) abort_pend_d = 1'b1;
        if (accept) begin
          if (beat_last) begin
            bad_d   = abort_act_q & ~is_last;
            state_d = S_DONE;
          end else begin
            idx_d       = idx_q + 1'b1;
            rd_addr     = idx_d[ADDR_WIDTH-1:0];
            abort_act_d = abort_pend_d;
          end
        end
      end
      default: begin
        if (!bad_q) count_d = count_q + 16'd1;
        abort_pend_d = 1'b0;
        abort_act_d  = 1'b0;
        bad_d        = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      abort_pend_q <= 1'b0;
      abort_act_q  <= 1'b0;
      bad_q        <= 1'b0;
      len_err_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      abort_pend_q <= abort_pend_d;
      abort_act_q  <= abort_act_d;
      bad_q        <= bad_d;
      len_err_q    <= len_err_d;
      count_q      <= count_d;
    end
  end

  // Buffer is never cleared by reset; writes are frozen while a frame is in flight
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
    rdata_q <= mem[rd_addr];
  end

  assign busy           = (state_q == S_PRIME) | in_send;
  assign done           = (state_q == S_DONE);
  assign done_bad       = done & bad_q;
  assign len_err        = len_err_q;
  assign frame_count    = count_q;
  assign tx_axis_tvalid = in_send;
  assign tx_axis_tdata  = in_send ? rdata_q : 8'h00;
  assign tx_axis_tlast  = in_send & beat_last;
  assign tx_axis_tuser  = in_send & abort_act_q & ~is_last;

endmodule

// File: tb/tb_eth_tx_frame_source.sv
// tb/tb_eth_tx_frame_source.sv - scoreboard bench for eth_tx_frame_source
// Expected beats come from a byte-array model of the buffer and the frame/abort rules.
module tb_eth_tx_frame_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [11:0] tx_len = '0;
  logic        tx_start = 1'b0;
  logic        tx_abort = 1'b0;
  logic        busy, done, done_bad, len_err;
  logic [15:0] frame_count;
  logic [7:0]  tx_axis_tdata;
  logic        tx_axis_tvalid;
  logic        tx_axis_tready = 1'b0;
  logic        tx_axis_tlast, tx_axis_tuser;

  always #4 clk = ~clk;

  eth_tx_frame_source #(.ADDR_WIDTH(11)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tx_len(tx_len), .tx_start(tx_start), .tx_abort(tx_abort),
    .busy(busy), .done(done), .done_bad(done_bad), .len_err(len_err),
    .frame_count(frame_count),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tready(tx_axis_tready), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tuser(tx_axis_tuser)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  logic  done_q[$];
  logic [7:0] mdl_mem [2048];
  int    mdl_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and enforces hold-while-stalled
  logic  pv = 1'b0, pr = 1'b0;
  beat_t pb;
  always @(negedge clk) begin
    beat_t act, e;
    logic  eb;
    act = {tx_axis_tdata, tx_axis_tlast, tx_axis_tuser};
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        checks++;
        if (!tx_axis_tvalid || act != pb) begin
          errors++;
          $display("FAIL stall_hold actual=v%0b %h expected=v1 %h", tx_axis_tvalid, act, pb);
        end
      end
      if (tx_axis_tvalid && tx_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act != e) begin
            errors++;
            $display("FAIL beat actual=%h expected=%h", act, e);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          eb = done_q.pop_front();
          if (done_bad !== eb) begin
            errors++;
            $display("FAIL done_bad actual=%0b expected=%0b", done_bad, eb);
          end
        end
      end else if (done_bad) begin
        checks++;
        errors++;
        $display("FAIL done_bad_alone actual=1 expected=0");
      end
      pv = tx_axis_tvalid;
      pr = tx_axis_tready;
      pb = act;
    end
  end

  task automatic fill(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_addr = 11'(i);
      wr_data = rnd ? 8'($urandom) : 8'(i);
      mdl_mem[i] = wr_data;
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic bad_len(input int len);
    tx_len = 12'(len);
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk("len_err_pulse", len_err, 1);
    chk("len_err_busy", busy, 0);
    @(posedge clk); #1;
    chk("len_err_one_cycle", len_err, 0);
    chk("len_err_no_valid", tx_axis_tvalid, 0);
  endtask

  // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random
  task automatic send(input int len, input int abort_at, input int mode,
                      input bit midwr, input int rst_at, input bit wr0, input bit exp_lat);
    bit bad;
    int n, edges, beats, phase;
    bit cur_v, cur_r, done_seen;
    if (wr0) mdl_mem[0] = 8'hA5;
    bad = (abort_at >= 0) && (abort_at + 1 < len - 1);
    n = bad ? abort_at + 2 : len;
    for (int k = 0; k < n; k++)
      exp_q.push_back({mdl_mem[k], k == n - 1, bad && (k == n - 1)});
    done_q.push_back(bad);

    tx_len = 12'(len);
    tx_start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = 8'hA5;
    end
    @(posedge clk); #1;
    tx_start = 1'b0;
    wr_en = 1'b0;
    edges = 1; beats = 0; phase = 0; cur_v = 0; cur_r = 0; done_seen = 0;
    while (!done_seen && edges < 20000) begin
      if (cur_v && cur_r) beats++;
      if (exp_lat && edges == 1) chk("prime_no_valid", tx_axis_tvalid, 0);
      if (exp_lat && edges == 2) chk("first_valid_t2", tx_axis_tvalid, 1);
      if (done) begin
        done_seen = 1;
        if (exp_lat) chk("done_cycle", edges, len + 2);
        break;
      end
      if (rst_at >= 0 && tx_axis_tvalid && beats == rst_at) begin
        rst = 1'b1;
        tx_axis_tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_tvalid", tx_axis_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", frame_count, 0);
        exp_q.delete();
        done_q.delete();
        mdl_count = 0;
        return;
      end
      tx_abort = tx_axis_tvalid && (beats == abort_at);
      if (midwr && tx_axis_tvalid && beats == 20) begin
        tx_start = 1'b1; tx_len = 12'd10;
        wr_en = 1'b1; wr_addr = 11'd5; wr_data = 8'hFF;
      end else begin
        tx_start = 1'b0; wr_en = 1'b0;
      end
      case (mode)
        0: tx_axis_tready = 1'b1;
        1: begin tx_axis_tready = (phase % 4 == 0) || (phase % 4 == 3); phase++; end
        default: tx_axis_tready = ($urandom % 4) != 0;
      endcase
      cur_v = tx_axis_tvalid;
      cur_r = tx_axis_tready;
      @(posedge clk); #1;
      edges++;
    end
    tx_abort = 1'b0; tx_start = 1'b0; wr_en = 1'b0;
    if (!done_seen) begin
      checks++; errors++;
      $display("FAIL frame_timeout actual=no_done expected=done");
    end
    if (!bad) mdl_count = (mdl_count + 1) % 65536;
    @(posedge clk); #1;
    chk("frame_count", frame_count, mdl_count);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int len, ab;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", tx_axis_tvalid, 0);
    chk("rst_tlast", tx_axis_tlast, 0);
    chk("rst_tuser", tx_axis_tuser, 0);
    chk("rst_tdata", tx_axis_tdata, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done", {done, done_bad, len_err}, 0);
    chk("rst_count0", frame_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill(60, 1'b0);
    send(60, -1, 0, 0, -1, 0, 1);
    send(60, -1, 1, 0, -1, 0, 0);

    bad_len(0);
    bad_len(2049);
    fill(2048, 1'b1);
    send(2048, -1, 0, 0, -1, 0, 1);

    send(60, 9, 0, 0, -1, 0, 0);
    send(60, 59, 0, 0, -1, 0, 0);
    send(60, 20, 1, 0, -1, 0, 0);

    send(60, -1, 0, 1, -1, 0, 0);
    send(8, -1, 2, 0, -1, 0, 0);

    send(60, -1, 0, 0, -1, 1, 0);

    send(60, -1, 0, 0, 30, 0, 0);
    send(60, -1, 0, 0, -1, 0, 1);

    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(1, 300);
      ab = ($urandom % 2) ? int'($urandom_range(0, len - 1)) : -1;
      send(len, ab, 2, 0, -1, 0, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("beats_drained", exp_q.size(), 0);
    chk("dones_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
